// File: rtl/st_aligner.sv
// st_aligner: store-side lane aligner between the MEM stage and the data
// memory port. It takes a core store (func3, byte address, rs2 data) and
// issues word-aligned writes with byte strobes. A store that spills past a
// word boundary becomes two sequential beats (A, then A+4). Alternatively,
// with ALLOW_MISALIGN=0, it is rejected with an error pulse and never
// touches memory.
//
// Ports
//   clk, rst_n           clock, async active-low reset
//   st_valid / st_ready  store request handshake (ready only in IDLE)
//   func3                000 sb, 001 sh, 010 sw; anything else is an error
//   st_addr, st_data     byte address and rs2 value (value in low bits)
//   st_done / st_err     one-cycle completion pulse, err coincident on reject
//   mem_req / mem_ack    write beat request, held until acked
//   mem_addr             word-aligned beat address
//   mem_wdata, mem_wstrb lane-aligned data and byte enables
module st_aligner #(
  parameter int ADDR_W         = 32,
  parameter int ALLOW_MISALIGN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [2:0]        func3,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  output logic              st_done,
  output logic              st_err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BEAT0 = 2'd1;
  localparam logic [1:0] BEAT1 = 2'd2;

  logic [1:0]        r_state;
  logic              r_cross;
  logic [31:0]       r_hi_data;
  logic [3:0]        r_hi_strb;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic              r_done;
  logic              r_err;

  logic [1:0]  w_off;
  logic [3:0]  w_mask;
  logic [31:0] w_dmask;
  logic        w_fvalid;
  logic [7:0]  w_strb8;
  logic [63:0] w_data64;
  logic        w_cross;
  logic        w_bad;
  logic        w_accept;

  assign w_off = st_addr[1:0];

  always_comb begin
    w_mask   = 4'h0;
    w_dmask  = 32'h0;
    w_fvalid = 1'b0;
    case (func3)
      3'b000: begin w_mask = 4'h1; w_dmask = 32'h0000_00FF; w_fvalid = 1'b1; end
      3'b001: begin w_mask = 4'h3; w_dmask = 32'h0000_FFFF; w_fvalid = 1'b1; end
      3'b010: begin w_mask = 4'hF; w_dmask = 32'hFFFF_FFFF; w_fvalid = 1'b1; end
      default: ;
    endcase
  end

  // Data is masked to the store width first so unused lanes come out zero.
  assign w_strb8  = {4'b0, w_mask} << w_off;
  assign w_data64 = {32'b0, st_data & w_dmask} << {w_off, 3'b000};
  assign w_cross  = |w_strb8[7:4];
  assign w_bad    = !w_fvalid || (w_cross && (ALLOW_MISALIGN == 0));
  assign w_accept = st_valid && (r_state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cross   <= 1'b0;
      r_hi_data <= 32'h0;
      r_hi_strb <= 4'h0;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= 32'h0;
      r_wstrb   <= 4'h0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_bad) begin
              // Rejected: pulse done+err next cycle, never raise mem_req.
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end else begin
              r_state   <= BEAT0;
              r_req     <= 1'b1;
              r_addr    <= {st_addr[ADDR_W-1:2], 2'b00};
              r_wdata   <= w_data64[31:0];
              r_wstrb   <= w_strb8[3:0];
              r_cross   <= w_cross;
              r_hi_data <= w_data64[63:32];
              r_hi_strb <= w_strb8[7:4];
            end
          end
        end
        BEAT0: begin
          if (mem_ack) begin
            if (r_cross) begin
              // Second beat goes to the next word; wraps at the top of memory.
              r_state <= BEAT1;
              r_addr  <= r_addr + ADDR_W'(4);
              r_wdata <= r_hi_data;
              r_wstrb <= r_hi_strb;
            end else begin
              r_state <= IDLE;
              r_req   <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        BEAT1: begin
          if (mem_ack) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign st_ready  = (r_state == IDLE);
  assign st_done   = r_done;
  assign st_err    = r_err;
  assign mem_req   = r_req;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_wstrb;

endmodule
